// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM encodings and
// the bit-counter width helper.
package serial_adder_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Bits needed to count 0..w-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/full_adder_d.sv
// Single-bit full adder cell used as the bit-slice datapath.
module full_adder_d (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: adds two WIDTH-bit operands one bit per clock, LSB first,
// through a single full_adder_d, with a start/busy/done handshake.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CW = cnt_width(WIDTH);

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-2:0] res_sr;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic             accept;
    logic             last;
    logic             fa_sum;
    logic             fa_cout;
    logic [WIDTH-1:0] res_next;

    full_adder_d u_fa (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // Result bits arrive LSB first and enter at the MSB end.
    assign res_next = {fa_sum, res_sr};

    // Next-state logic; encoding 2'd3 falls back to IDLE.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        last    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (cnt_q == CW'(WIDTH - 1)) begin
                    last    = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            a_sr    <= '0;
            b_sr    <= '0;
            res_sr  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            busy    <= (state_d == RUN);
            done    <= (state_d == DONE);
            if (accept) begin
                a_sr    <= a;
                b_sr    <= b;
                carry_q <= cin;
                cnt_q   <= '0;
            end else if (state_q == RUN) begin
                a_sr    <= a_sr >> 1;
                b_sr    <= b_sr >> 1;
                carry_q <= fa_cout;
                res_sr  <= res_next[WIDTH-1:1];
                cnt_q   <= cnt_q + CW'(1);
                if (last) begin
                    sum  <= res_next;
                    cout <= fa_cout;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8 directed/random, WIDTH=3 exhaustive).
module tb_serial_adder_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       cin8;
    logic       busy8;
    logic       done8;
    logic [7:0] sum8;
    logic       cout8;

    logic       start3;
    logic [2:0] a3;
    logic [2:0] b3;
    logic       cin3;
    logic       busy3;
    logic       done3;
    logic [2:0] sum3;
    logic       cout3;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .cin   (cin8),
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .cout  (cout8)
    );

    serial_adder_ctrl #(.WIDTH(3)) dut3 (
        .clk   (clk),
        .rst   (rst),
        .start (start3),
        .a     (a3),
        .b     (b3),
        .cin   (cin3),
        .busy  (busy3),
        .done  (done3),
        .sum   (sum3),
        .cout  (cout3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Starts one WIDTH=8 addition and checks latency, busy, hold and result.
    // With disturb set, a is changed and start pulsed mid-run.
    task automatic run8(input string tag, input logic [7:0] ra, input logic [7:0] rb,
                        input logic rc, input bit disturb);
        logic [8:0] exp;
        logic [7:0] prev_sum;
        logic       prev_cout;
        int n;
        int nbusy;
        exp       = 9'(ra) + 9'(rb) + 9'(rc);
        prev_sum  = sum8;
        prev_cout = cout8;
        a8 = ra; b8 = rb; cin8 = rc; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        n = 0;
        nbusy = 0;
        while (!done8 && n < 20) begin
            if (busy8) nbusy++;
            if (sum8 !== prev_sum || cout8 !== prev_cout) begin
                chk({tag, "_hold"}, {sum8, cout8}, {prev_sum, prev_cout});
            end
            if (disturb && n == 3) begin
                a8 = 8'h11;
                start8 = 1'b1;
            end
            if (disturb && n == 4) start8 = 1'b0;
            tick();
            n++;
        end
        chk({tag, "_latency"}, 64'(n), 64'd8);
        chk({tag, "_busycycles"}, 64'(nbusy), 64'd8);
        chk({tag, "_busy_in_done"}, 64'(busy8), 64'd0);
        chk({tag, "_result"}, {55'd0, cout8, sum8}, {55'd0, exp});
        tick();
        chk({tag, "_done_pulse"}, 64'(done8), 64'd0);
        if (disturb) begin
            for (int i = 0; i < 10; i++) begin
                if (busy8 || done8) chk({tag, "_no_second_op"}, {busy8, done8}, 2'b00);
                tick();
            end
            chk({tag, "_idle_after"}, {busy8, done8}, 2'b00);
        end
    endtask

    // One WIDTH=3 addition checked against plain arithmetic.
    task automatic run3(input logic [2:0] ra, input logic [2:0] rb, input logic rc);
        logic [3:0] exp;
        int n;
        exp = 4'(ra) + 4'(rb) + 4'(rc);
        a3 = ra; b3 = rb; cin3 = rc; start3 = 1'b1;
        tick();
        start3 = 1'b0;
        n = 0;
        while (!done3 && n < 10) begin
            tick();
            n++;
        end
        checks++;
        assert (n == 3 && {cout3, sum3} === exp)
        else begin
            errors++;
            $error("FAIL w3_case a=%0h b=%0h cin=%0d observed=%0h latency=%0d expected=%0h latency=3",
                   ra, rb, rc, {cout3, sum3}, n, exp);
        end
        tick();
    endtask

    initial begin
        int n;
        int first_done;
        int second_done;
        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start3 = 1'b0; a3 = '0; b3 = '0; cin3 = 1'b0;
        tick();
        tick();
        chk("reset_outputs", {busy8, done8, cout8, sum8}, 11'd0);
        rst = 1'b0;
        tick();
        chk("idle_outputs", {busy8, done8}, 2'b00);

        run8("zero", 8'h00, 8'h00, 1'b0, 1'b0);
        run8("ff_01", 8'hFF, 8'h01, 1'b0, 1'b0);
        run8("a5_5a_disturb", 8'hA5, 8'h5A, 1'b1, 1'b1);

        // Abort mid-run with reset.
        a8 = 8'h3C; b8 = 8'h42; cin8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick(); tick(); tick();
        chk("abort_busy_before", 64'(busy8), 64'd1);
        rst = 1'b1;
        tick();
        chk("abort_outputs", {busy8, done8, cout8, sum8}, 11'd0);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (done8 || busy8) chk("abort_no_done", {busy8, done8}, 2'b00);
            tick();
        end
        run8("after_abort", 8'h01, 8'h01, 1'b0, 1'b0);

        // rst and start together: rst wins.
        rst = 1'b1; start8 = 1'b1;
        tick();
        rst = 1'b0; start8 = 1'b0;
        tick();
        chk("rst_beats_start", {busy8, done8}, 2'b00);

        // Back-to-back with start held.
        a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
        tick();
        a8 = 8'h7F; b8 = 8'h01;
        n = 0; first_done = -1; second_done = -1;
        while (n < 40 && second_done < 0) begin
            if (done8) begin
                if (first_done < 0) begin
                    first_done = n;
                    chk("b2b_first_result", {cout8, sum8}, 9'h030);
                end else begin
                    second_done = n;
                    chk("b2b_second_result", {cout8, sum8}, 9'h080);
                end
            end else if (first_done >= 0) begin
                start8 = 1'b0;
                if (busy8) chk("b2b_hold_30", {cout8, sum8}, 9'h030);
            end
            tick();
            n++;
        end
        chk("b2b_first_latency", 64'(first_done), 64'd8);
        chk("b2b_spacing", 64'(second_done - first_done), 64'd9);
        start8 = 1'b0;
        tick(); tick();

        for (int i = 0; i < 20; i++) begin
            run8("random", 8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
        end

        for (int i = 0; i < 128; i++) begin
            logic [6:0] v;
            v = 7'(i);
            run3(v[6:4], v[3:1], v[0]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
